dec_sched: RTL and testbench

Round-robin countdown scheduler that shares one 20-bit decrementer (`dec`) among `N_CH` countdown channels. Software or control logic loads a start value into a channel. Each cycle the scheduler grants the decrementer to one armed channel and writes the result back. When a channel reaches zero it pulses its expire flag and disarms. It sits between the control unit and the single `dec` instance, which is instantiated outside this block and connected through the `dec_a`/`dec_y` ports.

---
 rtl/dec_sched.sv | 94 +++++++++
 tb/tb_dec_sched.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_sched.sv
// dec_sched: round-robin countdown scheduler that time-shares one external
// W-bit decrementer among N_CH channels and pulses expire when a count reaches zero.
module dec_sched #(
    parameter int N_CH = 4,
    parameter int W    = 20,
    parameter int CW   = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_en,
    input  logic [CW-1:0]   load_ch,
    input  logic [W-1:0]    load_val,
    input  logic            cancel_en,
    input  logic [CW-1:0]   cancel_ch,
    output logic [W-1:0]    dec_a,
    input  logic [W-1:0]    dec_y,
    output logic            gnt_valid,
    output logic [CW-1:0]   gnt_ch,
    output logic [N_CH-1:0] armed,
    output logic [N_CH-1:0] expire,
    output logic            busy
);

    logic [W-1:0]    cnt [N_CH];
    logic [CW-1:0]   ptr;
    logic [N_CH-1:0] elig;
    logic [CW-1:0]   idx;
    logic            cancel_hit;

    // A channel being loaded this cycle sits out arbitration so load never races a writeback.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            elig[i] = armed[i] && !(load_en && load_ch == CW'(i));
        end
    end

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_ch    = '0;
        idx       = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = ptr + CW'(k);
            if (!gnt_valid && elig[idx]) begin
                gnt_valid = 1'b1;
                gnt_ch    = idx;
            end
        end
        if (rst) begin
            gnt_valid = 1'b0;
            gnt_ch    = '0;
        end
    end

    assign dec_a      = gnt_valid ? cnt[gnt_ch] : '0;
    assign busy       = |armed;
    assign cancel_hit = cancel_en && (cancel_ch == gnt_ch);

    // NOTE: state is updated with non-blocking assignments; later statements win,
    // which gives the priority load > cancel > decrement writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the small count array is reset along with the flags so every
            // channel starts from a defined zero count.
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
            armed  <= '0;
            expire <= '0;
            ptr    <= '0;
        end else begin
            expire <= '0;
            if (gnt_valid) begin
                ptr <= gnt_ch + 1'b1;
                if (!cancel_hit) begin
                    cnt[gnt_ch] <= dec_y;
                    if (cnt[gnt_ch] == W'(1)) begin
                        armed[gnt_ch]  <= 1'b0;
                        expire[gnt_ch] <= 1'b1;
                    end
                end
            end
            if (cancel_en) begin
                armed[cancel_ch] <= 1'b0;
            end
            if (load_en) begin
                cnt[load_ch]    <= load_val;
                armed[load_ch]  <= (load_val != '0);
                expire[load_ch] <= (load_val == '0);
            end
        end
    end

endmodule

// File: tb/tb_dec_sched.sv
// Self-checking bench for dec_sched: directed vector table, hand-written corner
// sequences, then random traffic against a behavioural model.
module tb_dec_sched;

    localparam int N_CH = 4;
    localparam int W    = 20;
    localparam int CW   = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            load_en;
    logic [CW-1:0]   load_ch;
    logic [W-1:0]    load_val;
    logic            cancel_en;
    logic [CW-1:0]   cancel_ch;
    logic [W-1:0]    dec_a;
    logic [W-1:0]    dec_y;
    logic            gnt_valid;
    logic [CW-1:0]   gnt_ch;
    logic [N_CH-1:0] armed;
    logic [N_CH-1:0] expire;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // The external decrementer.
    assign dec_y = dec_a - 20'd1;

    dec_sched #(.N_CH(N_CH), .W(W)) dut (
        .clk(clk), .rst(rst),
        .load_en(load_en), .load_ch(load_ch), .load_val(load_val),
        .cancel_en(cancel_en), .cancel_ch(cancel_ch),
        .dec_a(dec_a), .dec_y(dec_y),
        .gnt_valid(gnt_valid), .gnt_ch(gnt_ch),
        .armed(armed), .expire(expire), .busy(busy)
    );

    typedef struct packed {
        logic          le;
        logic [CW-1:0] lch;
        logic [W-1:0]  lval;
        logic          ce;
        logic [CW-1:0] cch;
        logic          gv;
        logic [CW-1:0] gch;
        logic [W-1:0]  da;
        logic [3:0]    arm;
        logic [3:0]    ex;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic le, input logic [CW-1:0] lch, input logic [W-1:0] lval,
                         input logic ce, input logic [CW-1:0] cch);
        load_en   = le;
        load_ch   = lch;
        load_val  = lval;
        cancel_en = ce;
        cancel_ch = cch;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic le, input int lch, input logic [W-1:0] lval,
                       input logic ce, input int cch, input logic gv, input int gch,
                       input logic [W-1:0] da, input logic [3:0] arm, input logic [3:0] ex);
        vec_t v;
        v.le = le;  v.lch = CW'(lch); v.lval = lval;
        v.ce = ce;  v.cch = CW'(cch);
        v.gv = gv;  v.gch = CW'(gch); v.da = da;
        v.arm = arm; v.ex = ex;
        tbl.push_back(v);
    endtask

    // Behavioural model state for the random phase.
    int         m_cnt [N_CH];
    bit [3:0]   m_arm;
    bit [3:0]   m_exp;
    int         m_ptr;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        check("reset armed", armed, 0);
        check("reset expire", expire, 0);
        check("reset busy", busy, 0);
        check("reset gnt_valid", gnt_valid, 0);

        // Single channel value 3, then load of 0.
        add(1, 0, 20'd3, 0, 0, 0, 0, 20'd0, 4'b0001, 4'b0000);
        add(0, 0, 20'd0, 0, 0, 1, 0, 20'd3, 4'b0001, 4'b0000);
        add(0, 0, 20'd0, 0, 0, 1, 0, 20'd2, 4'b0001, 4'b0000);
        add(0, 0, 20'd0, 0, 0, 1, 0, 20'd1, 4'b0000, 4'b0001);
        add(0, 0, 20'd0, 0, 0, 0, 0, 20'd0, 4'b0000, 4'b0000);
        add(1, 2, 20'd0, 0, 0, 0, 0, 20'd0, 4'b0000, 4'b0100);
        add(0, 0, 20'd0, 0, 0, 0, 0, 20'd0, 4'b0000, 4'b0000);
        // Round robin: pointer is at 1 here.
        add(1, 0, 20'd3, 0, 0, 0, 0, 20'd0, 4'b0001, 4'b0000);
        add(1, 1, 20'd3, 0, 0, 1, 0, 20'd3, 4'b0011, 4'b0000);
        add(1, 2, 20'd3, 0, 0, 1, 1, 20'd3, 4'b0111, 4'b0000);
        add(1, 3, 20'd3, 0, 0, 1, 2, 20'd3, 4'b1111, 4'b0000);
        add(0, 0, 20'd0, 0, 0, 1, 3, 20'd3, 4'b1111, 4'b0000);
        add(0, 0, 20'd0, 0, 0, 1, 0, 20'd2, 4'b1111, 4'b0000);
        add(0, 0, 20'd0, 0, 0, 1, 1, 20'd2, 4'b1111, 4'b0000);
        add(0, 0, 20'd0, 0, 0, 1, 2, 20'd2, 4'b1111, 4'b0000);
        add(0, 0, 20'd0, 0, 0, 1, 3, 20'd2, 4'b1111, 4'b0000);
        add(0, 0, 20'd0, 0, 0, 1, 0, 20'd1, 4'b1110, 4'b0001);
        add(0, 0, 20'd0, 0, 0, 1, 1, 20'd1, 4'b1100, 4'b0010);
        add(0, 0, 20'd0, 0, 0, 1, 2, 20'd1, 4'b1000, 4'b0100);
        add(0, 0, 20'd0, 0, 0, 1, 3, 20'd1, 4'b0000, 4'b1000);
        add(0, 0, 20'd0, 0, 0, 0, 0, 20'd0, 4'b0000, 4'b0000);
        // Reload ch0 mid-count: no grant in the load cycle, no expire for the old count.
        add(1, 0, 20'd2, 0, 0, 0, 0, 20'd0, 4'b0001, 4'b0000);
        add(1, 0, 20'd2, 0, 0, 0, 0, 20'd0, 4'b0001, 4'b0000);
        add(0, 0, 20'd0, 0, 0, 1, 0, 20'd2, 4'b0001, 4'b0000);
        add(0, 0, 20'd0, 0, 0, 1, 0, 20'd1, 4'b0000, 4'b0001);

        foreach (tbl[i]) begin
            drive(tbl[i].le, tbl[i].lch, tbl[i].lval, tbl[i].ce, tbl[i].cch);
            #1;
            check($sformatf("row%0d gnt_valid", i), gnt_valid, tbl[i].gv);
            check($sformatf("row%0d gnt_ch", i), gnt_ch, tbl[i].gch);
            check($sformatf("row%0d dec_a", i), dec_a, tbl[i].da);
            tick();
            check($sformatf("row%0d armed", i), armed, tbl[i].arm);
            check($sformatf("row%0d expire", i), expire, tbl[i].ex);
            check($sformatf("row%0d busy", i), busy, (tbl[i].arm != 0));
        end

        // Large value: no wrap, then a cancel that collides with the grant.
        drive(1'b1, 2'd1, 20'hFFFFF, 1'b0, '0);
        tick();
        check("big armed", armed, 4'b0010);
        for (int k = 0; k < 5; k++) begin
            idle();
            #1;
            check($sformatf("big gnt_ch %0d", k), gnt_ch, 1);
            check($sformatf("big dec_a %0d", k), dec_a, 20'hFFFFF - k);
            tick();
        end
        drive(1'b0, '0, '0, 1'b1, 2'd1);
        #1;
        check("cancel gnt_valid", gnt_valid, 1);
        check("cancel dec_a", dec_a, 20'hFFFFA);
        tick();
        check("cancel armed", armed, 0);
        check("cancel expire", expire, 0);
        idle();
        #1;
        check("cancel idle gnt", gnt_valid, 0);
        tick();
        check("cancel late expire", expire, 0);

        // Load of 1 expires after exactly one grant.
        drive(1'b1, 2'd1, 20'd1, 1'b0, '0);
        tick();
        check("one armed", armed, 4'b0010);
        idle();
        #1;
        check("one dec_a", dec_a, 20'd1);
        check("one gnt_ch", gnt_ch, 1);
        tick();
        check("one expire", expire, 4'b0010);
        check("one armed after", armed, 0);
        tick();
        check("one expire cleared", expire, 0);

        // Load and cancel on ch3 together: load wins.
        drive(1'b1, 2'd3, 20'd5, 1'b1, 2'd3);
        tick();
        check("load+cancel armed", armed, 4'b1000);
        drive(1'b1, 2'd0, 20'd5, 1'b0, '0);
        tick();
        drive(1'b1, 2'd1, 20'd5, 1'b0, '0);
        tick();
        check("three armed", armed, 4'b1011);

        // Reset mid-count drops everything silently.
        rst = 1'b1;
        idle();
        #1;
        check("rst gnt_valid", gnt_valid, 0);
        check("rst gnt_ch", gnt_ch, 0);
        check("rst dec_a", dec_a, 0);
        tick();
        check("rst armed", armed, 0);
        check("rst expire", expire, 0);
        check("rst busy", busy, 0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("post-rst gnt %0d", k), gnt_valid, 0);
            tick();
            check($sformatf("post-rst expire %0d", k), expire, 0);
        end

        // Random traffic against the behavioural model.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
        m_arm = '0;
        m_exp = '0;
        m_ptr = 0;
        for (int t = 0; t < 1500; t++) begin
            logic          le, ce;
            logic [CW-1:0] lch, cch;
            logic [W-1:0]  lval;
            logic [31:0]   r;
            bit            mgv;
            int            mg, best;
            bit [3:0]      nexp;

            le   = ($urandom_range(0, 3) == 0);
            lch  = CW'($urandom_range(0, 3));
            r    = $urandom;
            lval = ($urandom_range(0, 7) == 0) ? r[W-1:0] : W'($urandom_range(0, 5));
            ce   = ($urandom_range(0, 9) == 0);
            cch  = CW'($urandom_range(0, 3));
            drive(le, lch, lval, ce, cch);

            // Grant: eligible channel at the smallest forward distance from the pointer.
            mgv  = 1'b0;
            mg   = 0;
            best = N_CH;
            for (int c = 0; c < N_CH; c++) begin
                int d;
                d = (c - m_ptr + N_CH) % N_CH;
                if (m_arm[c] && !(le && int'(lch) == c) && d < best) begin
                    best = d;
                    mg   = c;
                    mgv  = 1'b1;
                end
            end
            #1;
            check($sformatf("rnd%0d gnt_valid", t), gnt_valid, mgv);
            check($sformatf("rnd%0d gnt_ch", t), gnt_ch, mgv ? mg : 0);
            check($sformatf("rnd%0d dec_a", t), dec_a, mgv ? m_cnt[mg] : 0);

            nexp = '0;
            if (mgv) begin
                m_ptr = (mg + 1) % N_CH;
                if (!(ce && int'(cch) == mg)) begin
                    if (m_cnt[mg] == 1) begin
                        m_arm[mg] = 1'b0;
                        nexp[mg]  = 1'b1;
                    end
                    m_cnt[mg] = m_cnt[mg] - 1;
                end
            end
            if (ce) m_arm[cch] = 1'b0;
            if (le) begin
                m_cnt[lch] = int'(lval);
                m_arm[lch] = (lval != 0);
                nexp[lch]  = (lval == 0);
            end
            m_exp = nexp;

            tick();
            check($sformatf("rnd%0d armed", t), armed, m_arm);
            check($sformatf("rnd%0d expire", t), expire, m_exp);
            check($sformatf("rnd%0d busy", t), busy, (m_arm != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
